// File: rtl/spi_scratchpad.sv
// Byte scratch buffer on the SPI command bus: burst writes, burst reads from a
// persistent read pointer, and a running XOR checksum of every byte written.
module spi_scratchpad #(
  parameter int         DEPTH           = 16,
  parameter logic [7:0] WRITE_OPCODE    = 8'hC0,
  parameter logic [7:0] READ_OPCODE     = 8'hC1,
  parameter logic [7:0] ADDRESS_OPCODE  = 8'hC2,
  parameter logic [7:0] CHECKSUM_OPCODE = 8'hC3
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic [7:0]  opcode_in,
  input  logic        opcode_valid_in,
  input  logic [7:0]  operand_in,
  input  logic        operand_valid_in,
  input  logic [31:0] operand_count_in,
  output logic [7:0]  response_out,
  output logic        response_valid_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ADDR  = 3'd1,
    S_WR_DATA  = 3'd2,
    S_READ     = 3'd3,
    S_CHECKSUM = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_ov_q;
  logic          r_addr_only;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [7:0]    r_cs;
  logic [7:0]    r_rd_q;
  logic [7:0]    r_resp;
  logic          r_resp_valid;
  logic [7:0]    r_mem [DEPTH];
  logic          w_rise;

  assign w_rise             = opcode_valid_in & ~r_ov_q;
  assign response_out       = r_resp;
  assign response_valid_out = r_resp_valid;

  // Sequencer: opcode decode, pointer/array/checksum updates and registered response.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state      <= S_IDLE;
      r_ov_q       <= 1'b0;
      r_addr_only  <= 1'b0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cs         <= 8'h00;
      r_rd_q       <= 8'h00;
      r_resp       <= 8'h00;
      r_resp_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      r_ov_q       <= opcode_valid_in;
      // Array read is staged once so response_out lags a pointer move by two cycles.
      r_rd_q       <= r_mem[r_rp];
      r_resp_valid <= (r_state == S_READ) || (r_state == S_CHECKSUM);

      case (r_state)
        S_READ:     r_resp <= r_rd_q;
        S_CHECKSUM: r_resp <= r_cs;
        default:    r_resp <= 8'h00;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_addr_only <= 1'b0;
            case (opcode_in)
              WRITE_OPCODE:    r_state <= S_WR_ADDR;
              ADDRESS_OPCODE: begin
                r_state     <= S_WR_ADDR;
                r_addr_only <= 1'b1;
              end
              READ_OPCODE:     r_state <= S_READ;
              CHECKSUM_OPCODE: r_state <= S_CHECKSUM;
              default:         r_state <= S_IGNORE;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WR_ADDR: begin
          if (operand_valid_in) begin
            if (operand_count_in != 32'd0) begin
              r_state <= S_IGNORE;
            end else if (r_addr_only) begin
              r_rp    <= operand_in[AW-1:0];
              r_state <= S_IGNORE;
            end else begin
              r_wp    <= operand_in[AW-1:0];
              r_state <= S_WR_DATA;
            end
          end else begin
            r_state <= S_WR_ADDR;
          end
        end
        S_WR_DATA: begin
          if (operand_valid_in) begin
            r_mem[r_wp] <= operand_in;
            r_cs        <= r_cs ^ operand_in;
            r_wp        <= r_wp + PTR_ONE;
          end else begin
            r_wp <= r_wp;
          end
        end
        S_READ: begin
          if (operand_valid_in) begin
            r_rp <= r_rp + PTR_ONE;
          end else begin
            r_rp <= r_rp;
          end
        end
        S_CHECKSUM: r_state <= S_CHECKSUM;
        S_IGNORE:   r_state <= S_IGNORE;
        default:    r_state <= S_IDLE;
      endcase

      // Chip-select release wins over any transition above, after the operand is taken.
      if (!opcode_valid_in) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_spi_scratchpad.sv
// Directed bench for spi_scratchpad: a transaction table plus hand-written
// sequences for chip-select drop, one-cycle gaps and reset mid-read.
module tb_spi_scratchpad;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  opcode_in;
  logic        opcode_valid_in;
  logic [7:0]  operand_in;
  logic        operand_valid_in;
  logic [31:0] operand_count_in;
  logic [7:0]  response_out;
  logic        response_valid_out;

  int tests = 0;
  int fails = 0;

  localparam logic [7:0] CS1 = 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'h11 ^ 8'h22;
  localparam logic [7:0] CS2 = CS1 ^ 8'h5A ^ 8'h6B;

  typedef struct {
    logic [7:0]       op;
    int               nops;
    logic [3:0][7:0]  opnd;
    int               nexp;
    logic [3:0][7:0]  exp;
    logic             ev;
  } vec_t;

  vec_t tbl [15];

  spi_scratchpad dut (
    .clock_in           (clk),
    .reset_n_in         (rst_n),
    .opcode_in          (opcode_in),
    .opcode_valid_in    (opcode_valid_in),
    .operand_in         (operand_in),
    .operand_valid_in   (operand_valid_in),
    .operand_count_in   (operand_count_in),
    .response_out       (response_out),
    .response_valid_out (response_valid_out)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] op, input int nops,
                              input logic [7:0] o0, input logic [7:0] o1,
                              input logic [7:0] o2, input logic [7:0] o3,
                              input int nexp,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3,
                              input logic ev);
    vec_t v;
    v.op   = op;
    v.nops = nops;
    v.opnd[0] = o0; v.opnd[1] = o1; v.opnd[2] = o2; v.opnd[3] = o3;
    v.nexp = nexp;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.ev   = ev;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] op);
    @(negedge clk);
    opcode_in       = op;
    opcode_valid_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] b, input int idx);
    operand_in       = b;
    operand_count_in = idx;
    operand_valid_in = 1'b1;
    @(negedge clk);
    operand_valid_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic stop_op(input int gap);
    opcode_valid_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int n;
    n = (v.nops > v.nexp) ? v.nops : v.nexp;
    start_op(v.op);
    for (int k = 0; k < n; k++) begin
      check({nm, "_valid"}, {7'd0, response_valid_out}, {7'd0, v.ev});
      if (k < v.nexp) check($sformatf("%s_rsp%0d", nm, k), response_out, v.exp[k]);
      if (k < v.nops) pulse(v.opnd[k], k);
    end
    stop_op(2);
    check({nm, "_valid_end"}, {7'd0, response_valid_out}, 8'h00);
  endtask

  initial begin
    tbl[0]  = mk(8'hC3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[1]  = mk(8'hC0, 4, 8'h03, 8'hAA, 8'hBB, 8'hCC, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[2]  = mk(8'hC2, 1, 8'h03, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[3]  = mk(8'hC1, 3, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'hAA, 8'hBB, 8'hCC, 8'h00, 1'b1);
    tbl[4]  = mk(8'hC0, 3, 8'h0F, 8'h11, 8'h22, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[5]  = mk(8'hC2, 1, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[6]  = mk(8'hC1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h11, 8'h22, 8'h00, 8'h00, 1'b1);
    tbl[7]  = mk(8'hC3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, CS1,   8'h00, 8'h00, 8'h00, 1'b1);
    tbl[8]  = mk(8'hC3, 2, 8'h55, 8'h66, 8'h00, 8'h00, 2, CS1,   CS1,   8'h00, 8'h00, 1'b1);
    tbl[9]  = mk(8'h55, 2, 8'h01, 8'h02, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[10] = mk(8'hC2, 1, 8'h03, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[11] = mk(8'hC1, 4, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'hAA, 8'hBB, 8'hCC, 8'h00, 1'b1);
    tbl[12] = mk(8'hC2, 1, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[13] = mk(8'hC1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h11, 8'h00, 8'h00, 1'b1);
    tbl[14] = mk(8'hC1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h22, 8'h00, 8'h00, 8'h00, 1'b1);

    rst_n = 1'b0; opcode_in = 8'h00; opcode_valid_in = 1'b0;
    operand_in = 8'h00; operand_valid_in = 1'b0; operand_count_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", {7'd0, response_valid_out}, 8'h00);
    check("rst_data", response_out, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", {7'd0, response_valid_out}, 8'h00);

    for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("t%0d", i));

    // Nonzero operand index on the address byte aborts the write.
    start_op(8'hC0);
    pulse(8'h08, 1);
    pulse(8'h77, 2);
    stop_op(2);
    run_txn(mk(8'hC2, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0), "cnt_addr");
    run_txn(mk(8'hC1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1), "cnt_rd");
    run_txn(mk(8'hC3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, CS1,   8'h00, 8'h00, 8'h00, 1'b1), "cnt_cs");

    // Last data byte arrives in the same cycle chip-select drops.
    start_op(8'hC0);
    pulse(8'h0A, 0);
    pulse(8'h5A, 1);
    operand_in = 8'h6B; operand_count_in = 32'd2;
    operand_valid_in = 1'b1; opcode_valid_in = 1'b0;
    @(negedge clk);
    operand_valid_in = 1'b0;
    repeat (2) @(negedge clk);

    // Address then read separated by a single low cycle of opcode_valid_in.
    start_op(8'hC2);
    pulse(8'h0A, 0);
    stop_op(0);
    start_op(8'hC1);
    check("b2b_valid", {7'd0, response_valid_out}, 8'h01);
    check("b2b_rsp0", response_out, 8'h5A);
    pulse(8'h00, 0);
    check("b2b_rsp1", response_out, 8'h6B);
    stop_op(2);
    check("b2b_valid_end", {7'd0, response_valid_out}, 8'h00);
    run_txn(mk(8'hC3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, CS2, 8'h00, 8'h00, 8'h00, 1'b1), "sameclk_cs");

    // Write dropped after its address byte, then reset mid-read.
    start_op(8'hC0);
    pulse(8'h02, 0);
    stop_op(2);
    run_txn(mk(8'hC3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, CS2, 8'h00, 8'h00, 8'h00, 1'b1), "drop_cs");
    start_op(8'hC1);
    pulse(8'h00, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {7'd0, response_valid_out}, 8'h00);
    check("midrst_data", response_out, 8'h00);
    repeat (2) @(negedge clk);
    opcode_valid_in = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(mk(8'hC3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1), "rst_cs");
    run_txn(mk(8'hC2, 1, 8'h0A, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0), "rst_addr");
    run_txn(mk(8'hC1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1), "rst_rd");
    run_txn(mk(8'hC1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1), "rst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
